// File: rtl/midi_pkg.sv
// Shared MIDI types, byte constants and event-building helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package midi_pkg;

    typedef enum logic [2:0] {
        NOTE_OFF   = 3'd0,
        NOTE_ON    = 3'd1,
        POLY_AT    = 3'd2,
        CC         = 3'd3,
        PROG       = 3'd4,
        CHAN_AT    = 3'd5,
        PITCH_BEND = 3'd6
    } msg_type_t;

    typedef struct packed {
        msg_type_t  msg_type;
        logic [3:0] channel;
        logic [6:0] data1;
        logic [6:0] data2;
    } midi_event_t;

    localparam logic [7:0] MIDI_CLOCK   = 8'hF8;
    localparam logic [7:0] ACTIVE_SENSE = 8'hFE;
    localparam logic [7:0] SYSEX_START  = 8'hF0;
    localparam logic [7:0] SYSEX_END    = 8'hF7;

    // Program change and channel pressure carry a single data byte.
    function automatic logic is_one_data(input logic [7:0] status);
        return (status[7:4] == 4'hC) || (status[7:4] == 4'hD);
    endfunction

    // Build an event from a channel-voice status and its data bytes.
    // A note-on with zero velocity is reported as a note-off.
    function automatic midi_event_t make_event(input logic [7:0] status,
                                               input logic [6:0] d1,
                                               input logic [6:0] d2);
        midi_event_t ev;
        ev.channel = status[3:0];
        ev.data1   = d1;
        ev.data2   = d2;
        case (status[7:4])
            4'h8:    ev.msg_type = NOTE_OFF;
            4'h9:    ev.msg_type = (d2 == 7'd0) ? NOTE_OFF : NOTE_ON;
            4'hA:    ev.msg_type = POLY_AT;
            4'hB:    ev.msg_type = CC;
            4'hC:    ev.msg_type = PROG;
            4'hD:    ev.msg_type = CHAN_AT;
            default: ev.msg_type = PITCH_BEND;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/midi_event_fifo.sv
// First-word-fall-through FIFO of decoded MIDI events with occupancy output.
// Latency: a pushed event is visible on pop_dat one cycle after the push edge.
// Backpressure: push on full is accepted only together with a pop; otherwise ignored (caller counts the drop).
module midi_event_fifo
    import midi_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     push_vld,
    input  midi_event_t              push_dat,
    output logic                     full,
    input  logic                     pop_rdy,
    output logic                     pop_vld,
    output midi_event_t              pop_dat,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    midi_event_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic          pop_ok;
    logic          push_ok;

    assign full    = (level_q == (AW + 1)'(DEPTH));
    assign pop_vld = (level_q != '0);
    assign pop_ok  = pop_rdy && pop_vld;
    // Full with a simultaneous pop frees a slot in the same cycle.
    assign push_ok = push_vld && (!full || pop_ok);
    // Storage is unreset, so gate the head word to keep outputs clean when empty.
    assign pop_dat = pop_vld ? mem[rd_ptr_q] : '0;
    assign level   = level_q;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
        end
    end

    // Event storage write port.
    always_ff @(posedge clk_in) begin
        if (push_ok) mem[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/midi_stream_parser.sv
// MIDI channel-voice parser with running status, SysEx/real-time filtering, timeout and event FIFO.
// Latency: final data byte sampled at edge k, event written at k+1, visible after k+1 if FIFO empty.
// Backpressure: valid/ready on the event side; events arriving on a full FIFO are dropped and counted.
module midi_stream_parser
    import midi_pkg::*;
#(
    parameter int          CLK_FREQ          = 100_000_000,
    parameter int          BAUD_RATE         = 31_250,
    parameter int          TIMEOUT_BYTES     = 3,
    parameter int          FIFO_DEPTH        = 8,
    parameter logic [15:0] CHANNEL_MASK      = 16'hFFFF,
    parameter bit          RUNNING_STATUS_EN = 1'b1
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          byte_valid_in,
    input  logic [7:0]                    byte_in,
    input  logic                          msg_ready_in,
    output logic                          msg_valid_out,
    output msg_type_t                     msg_type_out,
    output logic [3:0]                    channel_out,
    output logic [6:0]                    data1_out,
    output logic [6:0]                    data2_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
    output logic                          overflow_out,
    input  logic                          overflow_clr_in,
    output logic [15:0]                   drop_count_out
);
    localparam longint unsigned TO_CYC =
        (longint'(TIMEOUT_BYTES) * 10 * longint'(CLK_FREQ)) / longint'(BAUD_RATE);
    localparam int TO_W = $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

    state_t        state_q, state_d;
    logic [7:0]    rs_q, rs_d;
    logic          rs_vld_q, rs_vld_d;
    logic [6:0]    d1_q, d1_d;
    logic [TO_W-1:0] to_cnt_q;
    logic          emit_vld_q;
    midi_event_t   emit_q;
    logic          overflow_q;
    logic [15:0]   drop_q;

    logic          byte_act, is_status, in_wait, timeout, take_d1, emit, abort;
    midi_event_t   evt;
    logic          fifo_full, fifo_pop, ovf;
    midi_event_t   head;
    logic [16:0]   drop_sum;

    // Real-time bytes are invisible to everything, including the timeout.
    assign byte_act  = byte_valid_in && (byte_in < MIDI_CLOCK);
    assign is_status = byte_in[7] && (byte_in < SYSEX_START);
    assign in_wait   = (state_q == WAIT_D1) || (state_q == WAIT_D2);
    assign timeout   = in_wait && !byte_act && (to_cnt_q == TO_W'(TO_CYC - 1));

    // Next-state, running status and event assembly.
    always_comb begin
        state_d  = state_q;
        rs_d     = rs_q;
        rs_vld_d = rs_vld_q;
        d1_d     = d1_q;
        take_d1  = 1'b0;
        emit     = 1'b0;
        abort    = 1'b0;
        evt      = '0;
        if (byte_act) begin
            if (is_status) begin
                abort    = in_wait;
                rs_d     = byte_in;
                rs_vld_d = 1'b1;
                state_d  = WAIT_D1;
            end else if (byte_in[7]) begin
                // System common: no drop counted even if a message was open.
                rs_vld_d = 1'b0;
                state_d  = (byte_in == SYSEX_START) ? SYSEX : IDLE;
            end else begin
                case (state_q)
                    IDLE:    take_d1 = rs_vld_q && RUNNING_STATUS_EN;
                    WAIT_D1: take_d1 = 1'b1;
                    WAIT_D2: begin
                        evt     = make_event(rs_q, d1_q, byte_in[6:0]);
                        emit    = 1'b1;
                        state_d = IDLE;
                    end
                    default: ;
                endcase
                if (take_d1) begin
                    d1_d = byte_in[6:0];
                    if (is_one_data(rs_q)) begin
                        evt     = make_event(rs_q, byte_in[6:0], 7'd0);
                        emit    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_D2;
                    end
                end
            end
        end else if (timeout) begin
            abort    = 1'b1;
            rs_vld_d = 1'b0;
            state_d  = IDLE;
        end
    end

    // Parser state, timeout counter and one-stage emit register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            rs_q       <= '0;
            rs_vld_q   <= 1'b0;
            d1_q       <= '0;
            to_cnt_q   <= '0;
            emit_vld_q <= 1'b0;
            emit_q     <= '0;
        end else begin
            state_q    <= state_d;
            rs_q       <= rs_d;
            rs_vld_q   <= rs_vld_d;
            d1_q       <= d1_d;
            if (!in_wait || byte_act || timeout) to_cnt_q <= '0;
            else                                 to_cnt_q <= to_cnt_q + TO_W'(1);
            // Masked channels are filtered here so they never reach the FIFO.
            emit_vld_q <= emit && CHANNEL_MASK[evt.channel];
            emit_q     <= evt;
        end
    end

    assign fifo_pop = msg_valid_out && msg_ready_in;
    assign ovf      = emit_vld_q && fifo_full && !fifo_pop;
    assign drop_sum = {1'b0, drop_q} + 17'(abort) + 17'(ovf);

    // Sticky overflow flag (a new overflow beats a clear) and saturating drop counter.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            if (ovf)                  overflow_q <= 1'b1;
            else if (overflow_clr_in) overflow_q <= 1'b0;
            drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    midi_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .push_vld (emit_vld_q),
        .push_dat (emit_q),
        .full     (fifo_full),
        .pop_rdy  (msg_ready_in),
        .pop_vld  (msg_valid_out),
        .pop_dat  (head),
        .level    (fifo_level_out)
    );

    assign msg_type_out   = head.msg_type;
    assign channel_out    = head.channel;
    assign data1_out      = head.data1;
    assign data2_out      = head.data2;
    assign overflow_out   = overflow_q;
    assign drop_count_out = drop_q;

endmodule

// File: tb/tb_midi_stream_parser.sv
// Self-checking bench: directed scenarios plus random byte streams against a message-level model.
// Latency: checks the two-edge byte-to-valid latency directly.
// Backpressure: ready held low, held high, or randomised per cycle.
module tb_midi_stream_parser;
    localparam int          CLK_FREQ = 1_000_000;
    localparam int          BAUD     = 31_250;
    localparam int          TO_BYTES = 3;
    localparam int          DEPTH    = 8;
    localparam logic [15:0] MASK     = 16'hFFFD;
    localparam int          TO_CYC   = TO_BYTES * 10 * CLK_FREQ / BAUD;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        byte_valid_in = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        msg_ready_in = 1'b0;
    logic        msg_valid_out;
    logic [2:0]  msg_type_out;
    logic [3:0]  channel_out;
    logic [6:0]  data1_out;
    logic [6:0]  data2_out;
    logic [3:0]  fifo_level_out;
    logic        overflow_out;
    logic        overflow_clr_in = 1'b0;
    logic [15:0] drop_count_out;

    midi_stream_parser #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .TIMEOUT_BYTES(TO_BYTES),
        .FIFO_DEPTH(DEPTH), .CHANNEL_MASK(MASK), .RUNNING_STATUS_EN(1'b1)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .byte_valid_in(byte_valid_in), .byte_in(byte_in),
        .msg_ready_in(msg_ready_in), .msg_valid_out(msg_valid_out), .msg_type_out(msg_type_out),
        .channel_out(channel_out), .data1_out(data1_out), .data2_out(data2_out),
        .fifo_level_out(fifo_level_out), .overflow_out(overflow_out),
        .overflow_clr_in(overflow_clr_in), .drop_count_out(drop_count_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (message level) ----------------
    logic [20:0] exp_q[$];
    int  m_rs   = -1;   // running status, -1 when invalid
    bit  m_open = 0;    // a channel message is in progress
    int  m_nd   = 0;    // data bytes collected so far
    int  m_d1   = 0;
    int  m_drop = 0;
    bit  m_ovf  = 0;
    int  ready_mode = 0; // 0 low, 1 high, 2 random

    function automatic int need(input int st);
        return ((st >> 4) == 12 || (st >> 4) == 13) ? 1 : 2;
    endfunction

    task automatic model_emit(input int st, input int d1, input int d2);
        int hi = st >> 4;
        int ch = st & 15;
        int ty = hi - 8;
        if (hi == 9 && d2 == 0) ty = 0;
        if (!MASK[ch]) return;
        // Only meaningful while ready has been held low since the queue was empty.
        if (ready_mode == 0 && exp_q.size() >= DEPTH) begin
            m_drop++;
            m_ovf = 1;
            return;
        end
        exp_q.push_back({3'(ty), 4'(ch), 7'(d1), 7'(d2)});
    endtask

    task automatic model_byte(input int b);
        if (b >= 'hF8) return;
        if (b >= 'h80 && b < 'hF0) begin
            if (m_open) m_drop++;
            m_rs = b; m_open = 1; m_nd = 0;
        end else if (b >= 'hF0) begin
            m_rs = -1; m_open = 0;
        end else begin
            if (!m_open && m_rs >= 0) begin m_open = 1; m_nd = 0; end
            if (m_open) begin
                if (m_nd == 0) m_d1 = b;
                m_nd++;
                if (m_nd == need(m_rs)) begin
                    model_emit(m_rs, m_d1, need(m_rs) == 1 ? 0 : b);
                    m_open = 0;
                end
            end
        end
    endtask

    task automatic model_timeout();
        if (m_open) begin m_drop++; m_open = 0; end
        m_rs = -1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rs = -1; m_open = 0; m_nd = 0; m_drop = 0; m_ovf = 0;
    endtask

    // Ready driver and scoreboard in one process so both see the same ready value.
    always @(negedge clk_in) begin
        case (ready_mode)
            0:       msg_ready_in = 1'b0;
            1:       msg_ready_in = 1'b1;
            default: msg_ready_in = 1'($urandom_range(0, 1));
        endcase
        if (rst_n_in && msg_valid_out && msg_ready_in) begin
            if (exp_q.size() == 0)
                check("unexpected_event", {msg_type_out, channel_out, data1_out, data2_out}, 32'hFFFFFFFF);
            else
                check("event", {msg_type_out, channel_out, data1_out, data2_out}, exp_q.pop_front());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input int b);
        @(negedge clk_in);
        byte_valid_in = 1'b1;
        byte_in = 8'(b);
        model_byte(b);
        @(negedge clk_in);
        byte_valid_in = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk_in);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic drain(input string tag);
        ready_mode = 1;
        settle(20);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_valid_low"}, msg_valid_out, 0);
        check({tag, "_drop"}, drop_count_out, m_drop);
    endtask

    initial begin
        // Reset state
        settle(3);
        check("rst_valid", msg_valid_out, 0);
        check("rst_level", fifo_level_out, 0);
        check("rst_ovf", overflow_out, 0);
        check("rst_drop", drop_count_out, 0);
        rst_n_in = 1'b1;
        settle(2);

        // Note-on with exact latency on the final data byte
        ready_mode = 0;
        send_byte('h90);
        send_byte('h3C);
        @(negedge clk_in);
        byte_valid_in = 1'b1; byte_in = 8'h64; model_byte('h64);
        @(negedge clk_in);
        byte_valid_in = 1'b0;
        check("lat_edge_k", msg_valid_out, 0);
        @(negedge clk_in);
        check("lat_edge_k1", msg_valid_out, 1);
        check("lat_event", {msg_type_out, channel_out, data1_out, data2_out},
              {3'd1, 4'd0, 7'h3C, 7'h64});
        check("lat_level", fifo_level_out, 1);
        drain("noteon");

        // Running status with velocity-zero note-off
        send_byte('h93); send_byte('h3C); send_byte('h64);
        send_byte('h3E); send_byte('h00);
        drain("running");

        // Real-time bytes interleaved
        send_byte('h90); send_byte('hF8); send_byte('h3C); send_byte('hFE); send_byte('h64);
        drain("realtime");

        // SysEx then orphan data, then program change
        send_byte('hF0); send_byte('h01); send_byte('h02); send_byte('hF7);
        send_byte('h3C); send_byte('h64);
        send_byte('hC5); send_byte('h07);
        drain("sysex_prog");

        // Masked channel 1
        send_byte('h91); send_byte('h3C); send_byte('h64);
        drain("masked");

        // Timeout mid-message; following data byte discarded
        send_byte('h90); send_byte('h3C);
        settle(TO_CYC + 40);
        model_timeout();
        check("timeout_drop", drop_count_out, m_drop);
        check("timeout_valid", msg_valid_out, 0);
        send_byte('h64);
        drain("after_timeout");

        // Overflow: nine note-ons with ready held low
        ready_mode = 0;
        settle(2);
        for (int i = 0; i < 9; i++) begin
            send_byte('h92); send_byte(16 + i); send_byte(1 + i);
        end
        settle(4);
        check("ovf_level", fifo_level_out, DEPTH);
        check("ovf_flag", overflow_out, m_ovf);
        check("ovf_drop", drop_count_out, m_drop);
        drain("ovf_drain");
        @(negedge clk_in); overflow_clr_in = 1'b1;
        @(negedge clk_in); overflow_clr_in = 1'b0;
        check("ovf_clear", overflow_out, 0);

        // Random byte stream with random backpressure
        ready_mode = 2;
        for (int i = 0; i < 500; i++) begin
            int r = $urandom_range(0, 99);
            int b;
            int wait_n = 0;
            while (exp_q.size() >= 6 && wait_n < 2000) begin
                @(negedge clk_in);
                wait_n++;
            end
            if (wait_n >= 2000) check("rand_stall", exp_q.size() < 6, 1);
            if (r < 22)      b = $urandom_range('h80, 'hEF);
            else if (r < 80) b = $urandom_range(0, 'h7F);
            else if (r < 90) b = $urandom_range('hF8, 'hFF);
            else             b = $urandom_range('hF0, 'hF7);
            send_byte(b);
        end
        drain("random");

        // Asynchronous reset mid-message with a pending event
        ready_mode = 0;
        send_byte('h94); send_byte('h30); send_byte('h31);
        send_byte('h90);
        settle(3);
        #2 rst_n_in = 1'b0;
        #1;
        model_reset();
        check("arst_valid", msg_valid_out, 0);
        check("arst_level", fifo_level_out, 0);
        check("arst_fields", {msg_type_out, channel_out, data1_out, data2_out}, 0);
        check("arst_ovf", overflow_out, 0);
        check("arst_drop", drop_count_out, 0);
        settle(2);
        rst_n_in = 1'b1;
        settle(2);
        send_byte('h3C); send_byte('h64);
        drain("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/midi_stream_parser.md
Name: midi_stream_parser

Overview:
Parametrised successor to the single-shot note decoder. Consumes the byte stream from uart_receive (31250 baud) and parses all MIDI channel-voice messages, with running status, real-time/SysEx filtering, channel masking and timeout recovery. Decoded events are pushed into an internal FIFO and presented on a valid/ready interface to downstream synth/display logic.

Parameters:
CLK_FREQ, 100_000_000, clock frequency in Hz
BAUD_RATE, 31_250, MIDI baud rate
TIMEOUT_BYTES, 3, byte-times allowed between consecutive message bytes before abort; TIMEOUT_CYCLES = TIMEOUT_BYTES*10*CLK_FREQ/BAUD_RATE
FIFO_DEPTH, 8, event FIFO depth; power of 2, >= 2
CHANNEL_MASK, 16'hFFFF, bit n = 1 accepts channel n
RUNNING_STATUS_EN, 1, 1 = accept data bytes under the previous status

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  reset
byte_valid_in  in  1  one-cycle strobe, new byte from UART
byte_in  in  8  received byte
msg_ready_in  in  1  downstream accepts event
msg_valid_out  out  1  event available (FIFO not empty)
msg_type_out  out  3  midi_pkg::msg_type_t
channel_out  out  4  MIDI channel 0-15
data1_out  out  7  note / controller / program / bend LSB / pressure
data2_out  out  7  velocity / value / bend MSB; 0 for 1-data-byte types
fifo_level_out  out  $clog2(FIFO_DEPTH)+1  current occupancy
overflow_out  out  1  sticky: event dropped on full FIFO
overflow_clr_in  in  1  clears overflow_out
drop_count_out  out  16  saturating count of dropped/aborted messages

Behaviour:
- Reset asynchronous, active-low (rst_n_in), single clock clk_in. All outputs 0, FIFO empty, running status invalid, state IDLE, timeout counter 0.
- Byte classes: real-time F8-FF; status 80-EF; system common F0-F7; data 00-7F.
- Real-time bytes: ignored completely; no state change, timeout counter not reset.
- States: IDLE, WAIT_D1, WAIT_D2, SYSEX.
- IDLE + status 80-EF: latch running status, -> WAIT_D1.
- IDLE + data byte: if running status valid and RUNNING_STATUS_EN, treat as D1; otherwise discard silently.
- WAIT_D1 + data: latch D1. Types C0 (program) and D0 (channel pressure) emit immediately -> IDLE. All other types -> WAIT_D2.
- WAIT_D2 + data: emit -> IDLE.
- Status byte arriving in WAIT_D1/WAIT_D2: abort partial message (drop_count++), restart on the new status.
- F0: -> SYSEX, running status cleared. SYSEX discards data bytes. F7 -> IDLE. Any 80-EF status exits SYSEX as a new status; no drop counted.
- F1-F6, F7 outside SYSEX: clear running status, -> IDLE; subsequent data bytes are discarded.
- Timeout: counter runs in WAIT_D1/WAIT_D2 and is reset by every non-real-time byte. Reaching TIMEOUT_CYCLES -> IDLE, running status cleared, drop_count++.
- Type mapping: 8n NOTE_OFF; 9n with velocity 0 NOTE_OFF, else NOTE_ON; An POLY_AT; Bn CC; Cn PROG; Dn CHAN_AT; En PITCH_BEND.
- Emit: events on channels with CHANNEL_MASK bit 0 are discarded, with no drop counted.
- Latency: final data byte sampled at edge k; event written to FIFO at edge k+1; msg_valid_out high after edge k+1 when FIFO was empty.
- FIFO is first-word-fall-through. Pop on msg_valid_out && msg_ready_in.
- Push on full without a same-cycle pop: event dropped, overflow_out set, drop_count++.
- Push and pop in the same cycle while full: both performed, level unchanged.
- overflow_clr_in clears overflow_out. A simultaneous overflow wins, so the flag stays set.
- drop_count_out saturates at 16'hFFFF.
- Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- midi_pkg:
  - msg_type_t enum (NOTE_OFF=0, NOTE_ON=1, POLY_AT=2, CC=3, PROG=4, CHAN_AT=5, PITCH_BEND=6)
  - midi_event_t struct {type, channel, data1, data2}
  - byte constants: MIDI_CLOCK 8'hF8, ACTIVE_SENSE 8'hFE, SYSEX_START 8'hF0, SYSEX_END 8'hF7
- Sub-module midi_event_fifo: parametrised FWFT sync FIFO of midi_event_t with level output, async active-low reset. Parser FSM stays in the top module.

Test Plan:
- 90 3C 64 -> one event NOTE_ON ch0 data1=3C data2=64, valid exactly 2 edges after the 64 strobe.
- 93 3C 64 3E 00 (running status) -> NOTE_ON ch3 3C/64, then NOTE_OFF ch3 3E/00.
- 90 F8 3C FE 64 -> single NOTE_ON 3C/64; real-time bytes invisible, drop_count stays 0.
- F0 01 02 F7 then 3C 64 with no status -> no events; then C5 07 -> PROG ch5 data1=07 data2=00.
- 90 3C then no bytes for TIMEOUT_CYCLES -> no event, drop_count=1; following 64 discarded.
- msg_ready_in=0, 9 note-ons with FIFO_DEPTH=8 -> level=8, overflow_out=1, drop_count=1; then ready=1 -> 8 events in order.
- Extra, CHANNEL_MASK=16'h0001: 91 3C 64 -> no event.
- Extra, rst_n_in low mid-message: all outputs 0 asynchronously.
